sdram_arbiter: RTL

- Arbitrates the single shared SDRAM byte/word controller between four requesters: video fetch port 1, video fetch port 2, CPU/FDD bus, and the ARM loader (misc) port.
- Sits between the top level and the SDRAM controller.
- Latches requests, grants one at a time by priority with loader anti-starvation, holds the backend handshake, and routes read data back to the owning requester.

---
 rtl/arb_pkg.sv | 7 +
 rtl/req_latch.sv | 66 ++++++
 rtl/sdram_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: requester/state encodings and the ROM image region prefix
// shared by the SDRAM arbiter and its request latch.
package arb_pkg;
    typedef enum logic [1:0] {REQ_V1, REQ_V2, REQ_CPU, REQ_MISC} req_e;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    localparam logic [4:0] ROM_PREFIX = 5'h10;
endpackage

// File: rtl/req_latch.sv
// req_latch: rising-edge capture of a level rd/we byte request, with a pending
// flag, captured address/data/direction, ready handshake and read-data return.
module req_latch
    import arb_pkg::*;
#(
    parameter int AW = 25
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          i_rd,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_din,
    input  logic          i_done,
    input  logic [7:0]    i_rdata,
    output logic          o_pend,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [7:0]    o_din,
    output logic [7:0]    o_dout,
    output logic          o_ready
);
    logic          r_act;
    logic          r_pend;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_din;
    logic [7:0]    r_dout;
    logic          r_ready;
    logic          w_rise;

    assign w_rise  = (i_rd | i_we) & ~r_act;
    assign o_pend  = r_pend;
    assign o_we    = r_we;
    assign o_addr  = r_addr;
    assign o_din   = r_din;
    assign o_dout  = r_dout;
    assign o_ready = r_ready;

    // A new capture outranks completion of the previous one in the same cycle.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_act   <= 1'b0;
            r_pend  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_dout  <= 8'hFF;
            r_ready <= 1'b1;
        end else begin
            r_act <= i_rd | i_we;
            if (i_done && !r_we)
                r_dout <= i_rdata;
            if (w_rise) begin
                r_pend  <= 1'b1;
                r_we    <= i_we;
                r_addr  <= i_addr;
                r_din   <= i_din;
                r_ready <= 1'b0;
            end else if (i_done) begin
                r_pend  <= 1'b0;
                r_ready <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: four-way arbiter (video1, video2, CPU, loader) in front of the SDRAM controller.
// Optional ARB_ROM_WP_EN: CPU writes into the ROM image region complete without touching SDRAM.
module sdram_arbiter
    import arb_pkg::*;
#(
    parameter int AW           = 25,
    parameter int VAW          = 19,
    parameter int STARVE_LIMIT = 8
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    input  logic           vid_req1,
    input  logic [VAW-1:0] vid_addr1,
    output logic [15:0]    vid_data1,
    input  logic           vid_req2,
    input  logic [VAW-1:0] vid_addr2,
    output logic [15:0]    vid_data2,
    input  logic           cpu_rd,
    input  logic           cpu_we,
    input  logic [AW-1:0]  cpu_addr,
    input  logic [7:0]     cpu_din,
    output logic [7:0]     cpu_dout,
    output logic           cpu_ready,
    input  logic           misc_rd,
    input  logic           misc_we,
    input  logic [AW-1:0]  misc_addr,
    input  logic [7:0]     misc_din,
    output logic [7:0]     misc_dout,
    output logic           misc_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           mem_wide,
    output logic [AW-1:0]  mem_addr,
    output logic [7:0]     mem_wdata,
    input  logic           mem_ack,
    input  logic [15:0]    mem_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_e         r_state;
    req_e           r_win;
    logic           r_ign;
    logic           r_mem_req;
    logic           r_mem_we;
    logic           r_mem_wide;
    logic [AW-1:0]  r_mem_addr;
    logic [7:0]     r_mem_wdata;
    logic [SW-1:0]  r_starve;
    logic           r_pv1;
    logic           r_pv2;
    logic [VAW-1:0] r_va1;
    logic [VAW-1:0] r_va2;
    logic [15:0]    r_vd1;
    logic [15:0]    r_vd2;

    logic           w_ack;
    logic           w_cpu_pend;
    logic           w_cpu_we;
    logic [AW-1:0]  w_cpu_addr;
    logic [7:0]     w_cpu_din;
    logic           w_cpu_done;
    logic           w_misc_pend;
    logic           w_misc_we;
    logic [AW-1:0]  w_misc_addr;
    logic [7:0]     w_misc_din;
    logic           w_wp;
    logic           w_cpu_elig;
    logic           w_any;
    logic           w_starved;
    req_e           w_pick;
    logic           w_we;
    logic [AW-1:0]  w_addr;
    logic [7:0]     w_wdata;

    assign w_ack      = (r_state == WAIT) && mem_ack && !r_ign;
    assign w_cpu_elig = w_cpu_pend && !w_wp;
    assign w_any      = r_pv1 || r_pv2 || w_cpu_elig || w_misc_pend;
    assign w_starved  = r_starve >= SW'(STARVE_LIMIT);

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_wide  = r_mem_wide;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign vid_data1 = r_vd1;
    assign vid_data2 = r_vd2;

    req_latch #(.AW(AW)) u_cpu (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_rd    (cpu_rd),
        .i_we    (cpu_we),
        .i_addr  (cpu_addr),
        .i_din   (cpu_din),
        .i_done  (w_cpu_done),
        .i_rdata (mem_rdata[7:0]),
        .o_pend  (w_cpu_pend),
        .o_we    (w_cpu_we),
        .o_addr  (w_cpu_addr),
        .o_din   (w_cpu_din),
        .o_dout  (cpu_dout),
        .o_ready (cpu_ready)
    );

    req_latch #(.AW(AW)) u_misc (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_rd    (misc_rd),
        .i_we    (misc_we),
        .i_addr  (misc_addr),
        .i_din   (misc_din),
        .i_done  (w_ack && r_win == REQ_MISC),
        .i_rdata (mem_rdata[7:0]),
        .o_pend  (w_misc_pend),
        .o_we    (w_misc_we),
        .o_addr  (w_misc_addr),
        .o_din   (w_misc_din),
        .o_dout  (misc_dout),
        .o_ready (misc_ready)
    );

`ifdef ARB_ROM_WP_EN
    logic r_wp_hit;

    // Protected writes sit pending one extra cycle, then retire as if acked.
    assign w_wp       = w_cpu_pend && w_cpu_we && (w_cpu_addr[AW-1 -: 5] == ROM_PREFIX);
    assign w_cpu_done = (w_ack && r_win == REQ_CPU) || r_wp_hit;

    always_ff @(posedge clk_sys) begin
        if (!rst_n)
            r_wp_hit <= 1'b0;
        else
            r_wp_hit <= w_wp && !r_wp_hit;
    end
`else
    assign w_wp       = 1'b0;
    assign w_cpu_done = w_ack && r_win == REQ_CPU;
`endif

    always_comb begin
        w_pick  = r_pv1 ? REQ_V1 :
                  r_pv2 ? REQ_V2 :
                  (w_misc_pend && (!w_cpu_elig || w_starved)) ? REQ_MISC : REQ_CPU;
        w_we    = (r_win == REQ_CPU) ? w_cpu_we : (r_win == REQ_MISC) ? w_misc_we : 1'b0;
        w_wdata = (r_win == REQ_MISC) ? w_misc_din : w_cpu_din;
        w_addr  = (r_win == REQ_V1)  ? {{(AW-VAW-1){1'b0}}, r_va1, 1'b0} :
                  (r_win == REQ_V2)  ? {{(AW-VAW-1){1'b0}}, r_va2, 1'b0} :
                  (r_win == REQ_CPU) ? w_cpu_addr : w_misc_addr;
    end

    // Reset while a request is outstanding arms the ignore flag for the one stale ack.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_win       <= REQ_V1;
            r_ign       <= r_ign | r_mem_req;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wide  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_starve    <= '0;
            r_pv1       <= 1'b0;
            r_pv2       <= 1'b0;
            r_va1       <= '0;
            r_va2       <= '0;
            r_vd1       <= '0;
            r_vd2       <= '0;
        end else begin
            r_pv1 <= vid_req1 || (r_pv1 && !(w_ack && r_win == REQ_V1));
            r_pv2 <= vid_req2 || (r_pv2 && !(w_ack && r_win == REQ_V2));
            r_va1 <= vid_req1 ? vid_addr1 : r_va1;
            r_va2 <= vid_req2 ? vid_addr2 : r_va2;
            if (w_ack && r_win == REQ_V1)
                r_vd1 <= mem_rdata;
            if (w_ack && r_win == REQ_V2)
                r_vd2 <= mem_rdata;
            if (mem_ack)
                r_ign <= 1'b0;
            if (r_state == IDLE) begin
                if (w_any) begin
                    r_state  <= ISSUE;
                    r_win    <= w_pick;
                    r_ign    <= 1'b0;
                    r_starve <= (w_pick == REQ_MISC) ? '0 :
                                (w_misc_pend && !w_starved) ? r_starve + 1'b1 : r_starve;
                end
            end else if (r_state == ISSUE) begin
                r_state     <= WAIT;
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_we;
                r_mem_wide  <= (r_win == REQ_V1) || (r_win == REQ_V2);
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
            end else if (w_ack) begin
                r_state   <= IDLE;
                r_mem_req <= 1'b0;
            end
        end
    end
endmodule
